// File: rtl/bp_common_pkg.sv
// bp_common_pkg: shared BlackParrot types and constants used by the CLINT
// command arbiter.
//   bp_params_e        - processor configuration selector
//   bp_xce_mem_msg_s   - CCE/XCE memory message carried on every port
//   xce_mem_msg_width  - packed width of bp_xce_mem_msg_s for a configuration
//   clint_arb_max_req_gp / clint_arb_timeout_gp - arbiter limits and defaults
package bp_common_pkg;

   typedef enum logic [1:0] {
      e_bp_default_cfg = 2'd0,
      e_bp_unicore_cfg = 2'd1
   } bp_params_e;

   typedef enum logic [3:0] {
      e_ce_mem_rd    = 4'h0,
      e_ce_mem_wr    = 4'h1,
      e_ce_mem_uc_rd = 4'h2,
      e_ce_mem_uc_wr = 4'h3
   } bp_xce_mem_cmd_e;

   typedef struct packed {
      bp_xce_mem_cmd_e msg_type;
      logic [2:0]      size;
      logic [39:0]     addr;
      logic [63:0]     data;
   } bp_xce_mem_msg_s;

   localparam int clint_arb_max_req_gp = 4;
   localparam int clint_arb_timeout_gp = 255;

   // All current configurations share one message layout.
   function automatic int xce_mem_msg_width(bp_params_e cfg);
      int w;
      case (cfg)
         default: w = $bits(bp_xce_mem_msg_s);
      endcase
      return w;
   endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small register-based FIFO, one write and one read
// port, valid/ready on the write side and valid/yumi on the read side.
//   clk_i, reset_i        - clock, asynchronous active-high reset
//   v_i, ready_o, data_i  - enqueue side; ready_o is simply "not full"
//   v_o, data_o, yumi_i   - dequeue side; yumi_i only while v_o
// A full FIFO never accepts, even when a dequeue happens on the same cycle.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 1,
   parameter int els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [els_p-1:0][width_p-1:0] mem_r;
   logic [ptr_w_lp-1:0]           rd_ptr_r, wr_ptr_r;
   logic [cnt_w_lp-1:0]           cnt_r;
   logic                          enq, deq;

   assign ready_o = (cnt_r != cnt_w_lp'(els_p));
   assign v_o     = (cnt_r != '0);
   assign data_o  = mem_r[rd_ptr_r];
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mem_r    <= '0;
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (enq) begin
            mem_r[wr_ptr_r] <= data_i;
            wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
         end
         if (deq)
            rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
         case ({enq, deq})
            2'b10:   cnt_r <= cnt_r + 1'b1;
            2'b01:   cnt_r <= cnt_r - 1'b1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/bp_clint_arb.sv
// bp_clint_arb: round-robin arbiter funnelling several command requesters
// into one CLINT slice, with in-order response routing via a tag FIFO.
//   clk_i, reset_n_i               - clock, asynchronous active-low reset
//   req_cmd_i/_v_i/_yumi_o         - requester commands in, one-hot accept
//   req_resp_o/_v_o/_yumi_i        - broadcast response, one-hot valid
//   clint_cmd_o/_v_o/_ready_i      - command to the CLINT slice
//   clint_resp_i/_v_i/_yumi_o      - response from the CLINT slice
//   timeout_o                      - sticky watchdog error
// Optional: define BP_CLINT_ARB_TIMEOUT_EN to build the response watchdog;
// otherwise timeout_o is tied low and no counter exists.
module bp_clint_arb
   import bp_common_pkg::*;
#(
   parameter bp_params_e bp_params_p       = e_bp_default_cfg,
   parameter int         num_req_p         = 2,
   parameter int         max_outstanding_p = 2,
   parameter int         timeout_p         = clint_arb_timeout_gp,
   localparam int        xce_mem_msg_width_lp = xce_mem_msg_width(bp_params_p)
) (
   input  logic                                      clk_i,
   input  logic                                      reset_n_i,

   input  logic [num_req_p*xce_mem_msg_width_lp-1:0] req_cmd_i,
   input  logic [num_req_p-1:0]                      req_cmd_v_i,
   output logic [num_req_p-1:0]                      req_cmd_yumi_o,

   output logic [xce_mem_msg_width_lp-1:0]           req_resp_o,
   output logic [num_req_p-1:0]                      req_resp_v_o,
   input  logic [num_req_p-1:0]                      req_resp_yumi_i,

   output logic [xce_mem_msg_width_lp-1:0]           clint_cmd_o,
   output logic                                      clint_cmd_v_o,
   input  logic                                      clint_cmd_ready_i,

   input  logic [xce_mem_msg_width_lp-1:0]           clint_resp_i,
   input  logic                                      clint_resp_v_i,
   output logic                                      clint_resp_yumi_o,

   output logic                                      timeout_o
);

   if (num_req_p < 2 || num_req_p > clint_arb_max_req_gp) begin : g_bad_num_req
      $error("bp_clint_arb: num_req_p out of range");
   end
   if (max_outstanding_p < 1) begin : g_bad_outstanding
      $error("bp_clint_arb: max_outstanding_p must be >= 1");
   end
   if (timeout_p < 1) begin : g_bad_timeout
      $error("bp_clint_arb: timeout_p must be >= 1");
   end

   localparam int tag_w_lp = $clog2(num_req_p);

   logic [tag_w_lp-1:0] rr_r, grant_id, tag_head;
   logic [tag_w_lp:0]   sum;
   logic [tag_w_lp-1:0] idx;
   logic                grant_found, fifo_ready, tag_v, enq, deq, resp_hit;
   logic                fifo_reset;

   // Search upward from the priority pointer, wrapping at num_req_p.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      sum         = '0;
      idx         = '0;
      for (int i = 0; i < num_req_p; i++) begin
         sum = {1'b0, rr_r} + (tag_w_lp+1)'(i);
         if (sum >= (tag_w_lp+1)'(num_req_p))
            sum = sum - (tag_w_lp+1)'(num_req_p);
         idx = sum[tag_w_lp-1:0];
         if (!grant_found && req_cmd_v_i[idx]) begin
            grant_found = 1'b1;
            grant_id    = idx;
         end
      end
   end

   // Outputs are gated by reset so nothing leaks out while held in reset.
   assign clint_cmd_v_o  = reset_n_i & fifo_ready & grant_found;
   assign clint_cmd_o    = reset_n_i ? req_cmd_i[int'(grant_id)*xce_mem_msg_width_lp +: xce_mem_msg_width_lp]
                                     : '0;
   assign enq            = clint_cmd_v_o & clint_cmd_ready_i;
   assign req_cmd_yumi_o = num_req_p'(enq) << grant_id;

   // Responses come back in issue order, so the FIFO head names the owner.
   assign resp_hit          = reset_n_i & clint_resp_v_i & tag_v;
   assign req_resp_v_o      = num_req_p'(resp_hit) << tag_head;
   assign deq               = resp_hit & req_resp_yumi_i[tag_head];
   assign clint_resp_yumi_o = deq;
   assign req_resp_o        = reset_n_i ? clint_resp_i : '0;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         rr_r <= '0;
      else if (enq)
         rr_r <= (grant_id == tag_w_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
   end

   assign fifo_reset = ~reset_n_i;

   bsg_fifo_1r1w_small #(
      .width_p (tag_w_lp),
      .els_p   (max_outstanding_p)
   ) tag_fifo (
      .clk_i   (clk_i),
      .reset_i (fifo_reset),
      .v_i     (enq),
      .ready_o (fifo_ready),
      .data_i  (grant_id),
      .v_o     (tag_v),
      .data_o  (tag_head),
      .yumi_i  (deq)
   );

`ifdef BP_CLINT_ARB_TIMEOUT_EN
   localparam int wd_w_lp = $clog2(timeout_p + 1);

   logic [wd_w_lp-1:0] wd_cnt_r, wd_cnt_n;
   logic               timeout_r;

   // Counts stalled cycles of the oldest outstanding command; saturates.
   always_comb begin
      wd_cnt_n = wd_cnt_r;
      if (!tag_v || deq)
         wd_cnt_n = '0;
      else if (wd_cnt_r != wd_w_lp'(timeout_p))
         wd_cnt_n = wd_cnt_r + 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wd_cnt_r  <= '0;
         timeout_r <= 1'b0;
      end else begin
         wd_cnt_r  <= wd_cnt_n;
         timeout_r <= timeout_r | (wd_cnt_n == wd_w_lp'(timeout_p));
      end
   end

   assign timeout_o = timeout_r;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_clint_arb.sv
// tb_bp_clint_arb: directed bench for bp_clint_arb (2 requesters, 2 tags,
// timeout_p=8). Define BP_CLINT_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_bp_clint_arb;
   import bp_common_pkg::*;

   localparam int W = xce_mem_msg_width(e_bp_default_cfg);
   localparam int N = 2;

   logic            clk_i = 1'b0;
   logic            reset_n_i;
   logic [N*W-1:0]  req_cmd_i;
   logic [N-1:0]    req_cmd_v_i, req_cmd_yumi_o;
   logic [W-1:0]    req_resp_o;
   logic [N-1:0]    req_resp_v_o, req_resp_yumi_i;
   logic [W-1:0]    clint_cmd_o;
   logic            clint_cmd_v_o, clint_cmd_ready_i;
   logic [W-1:0]    clint_resp_i;
   logic            clint_resp_v_i, clint_resp_yumi_o, timeout_o;

   logic [W-1:0]    m0, m1, ra, rb;
   int              n_chk = 0, n_err = 0;

   always #5 clk_i = ~clk_i;

   bp_clint_arb #(
      .bp_params_p       (e_bp_default_cfg),
      .num_req_p         (N),
      .max_outstanding_p (2),
      .timeout_p         (8)
   ) dut (
      .clk_i             (clk_i),
      .reset_n_i         (reset_n_i),
      .req_cmd_i         (req_cmd_i),
      .req_cmd_v_i       (req_cmd_v_i),
      .req_cmd_yumi_o    (req_cmd_yumi_o),
      .req_resp_o        (req_resp_o),
      .req_resp_v_o      (req_resp_v_o),
      .req_resp_yumi_i   (req_resp_yumi_i),
      .clint_cmd_o       (clint_cmd_o),
      .clint_cmd_v_o     (clint_cmd_v_o),
      .clint_cmd_ready_i (clint_cmd_ready_i),
      .clint_resp_i      (clint_resp_i),
      .clint_resp_v_i    (clint_resp_v_i),
      .clint_resp_yumi_o (clint_resp_yumi_o),
      .timeout_o         (timeout_o)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      req_cmd_v_i       = '0;
      req_resp_yumi_i   = '0;
      clint_cmd_ready_i = 1'b1;
      clint_resp_v_i    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL bench_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [N-1:0] g_exp [3];
      logic [N-1:0] r_exp [3];
      m0 = W'(128'h1_0000_0000_0000_00A0);
      m1 = W'(128'h2_0000_0000_0000_00B1);
      ra = W'(128'h7_1234_5678_9ABC_DEF0);
      rb = W'(128'h3_0FED_CBA9_8765_4321);
      req_cmd_i    = {m1, m0};
      clint_resp_i = ra;

      // Reset: everything low even with live inputs.
      reset_n_i = 1'b0;
      idle();
      req_cmd_v_i = 2'b11; clint_resp_v_i = 1'b1; req_resp_yumi_i = 2'b11;
      #3;
      chk("rst_cmd_v", clint_cmd_v_o, 0);
      chk("rst_cmd_yumi", req_cmd_yumi_o, 0);
      chk("rst_cmd_o", clint_cmd_o, 0);
      chk("rst_resp_v", req_resp_v_o, 0);
      chk("rst_resp_yumi", clint_resp_yumi_o, 0);
      chk("rst_timeout", timeout_o, 0);
      cyc(); cyc();
      reset_n_i = 1'b1;

      // Continuous requests, always ready, draining each cycle: 0,1,0,1.
      #1;
      chk("alt1_yumi", req_cmd_yumi_o, 2'b01);
      chk("alt1_cmd_o", clint_cmd_o, m0);
      chk("alt1_resp_v_empty", req_resp_v_o, 0);
      chk("alt1_stray_resp", clint_resp_yumi_o, 0);
      g_exp = '{2'b10, 2'b01, 2'b10};
      r_exp = '{2'b01, 2'b10, 2'b01};
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         chk("alt_yumi", req_cmd_yumi_o, g_exp[i]);
         chk("alt_resp_v", req_resp_v_o, r_exp[i]);
      end
      chk("alt4_cmd_o", clint_cmd_o, m1);
      cyc(); req_cmd_v_i = '0; #1;
      chk("alt5_resp_v", req_resp_v_o, 2'b10);
      chk("alt5_cmd_v", clint_cmd_v_o, 0);
      cyc(); #1;
      chk("alt6_empty", req_resp_v_o, 0);
      idle();

      // Two outstanding, response delayed: third command blocked.
      req_cmd_v_i = 2'b11; #1;
      chk("blk_g0", req_cmd_yumi_o, 2'b01);
      cyc(); #1;
      chk("blk_g1", req_cmd_yumi_o, 2'b10);
      cyc(); #1;
      chk("blk_full_v", clint_cmd_v_o, 0);
      chk("blk_full_yumi", req_cmd_yumi_o, 0);
      cyc(); clint_resp_v_i = 1'b1; req_resp_yumi_i = 2'b01; #1;
      chk("blk_resp_v", req_resp_v_o, 2'b01);
      chk("blk_resp_yumi", clint_resp_yumi_o, 1);
      chk("blk_no_bypass", clint_cmd_v_o, 0);
      cyc(); clint_resp_v_i = 1'b0; #1;
      chk("blk_reopen_v", clint_cmd_v_o, 1);
      chk("blk_reopen_g", req_cmd_yumi_o, 2'b01);
      cyc(); req_cmd_v_i = '0; clint_resp_v_i = 1'b1; req_resp_yumi_i = 2'b11; #1;
      chk("blk_drain1", req_resp_v_o, 2'b10);
      cyc(); #1;
      chk("blk_drain0", req_resp_v_o, 2'b01);
      cyc(); idle();

      // Issue req1 then req0; responses A then B route in issue order.
      req_cmd_v_i = 2'b10; #1;
      chk("ord_g1", req_cmd_yumi_o, 2'b10);
      chk("ord_cmd1", clint_cmd_o, m1);
      cyc(); req_cmd_v_i = 2'b01; #1;
      chk("ord_g0", req_cmd_yumi_o, 2'b01);
      cyc(); req_cmd_v_i = '0;
      clint_resp_v_i = 1'b1; clint_resp_i = ra; req_resp_yumi_i = 2'b11; #1;
      chk("ord_a_v", req_resp_v_o, 2'b10);
      chk("ord_a_msg", req_resp_o, ra);
      cyc(); clint_resp_i = rb; #1;
      chk("ord_b_v", req_resp_v_o, 2'b01);
      chk("ord_b_msg", req_resp_o, rb);
      cyc(); idle();

      // Head holds yumi low for 5 cycles, then a non-head yumi, then accept.
      req_cmd_v_i = 2'b01; #1;
      chk("hold_g0", req_cmd_yumi_o, 2'b01);
      cyc(); req_cmd_v_i = '0; clint_resp_v_i = 1'b1; req_resp_yumi_i = 2'b00;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_yumi", clint_resp_yumi_o, 0);
         chk("hold_pending", req_resp_v_o, 2'b01);
         cyc();
      end
      req_resp_yumi_i = 2'b10; #1;
      chk("hold_nonhead", clint_resp_yumi_o, 0);
      cyc(); req_resp_yumi_i = 2'b01; #1;
      chk("hold_accept", clint_resp_yumi_o, 1);
      cyc(); idle();

      // Reset with one tag outstanding; stray response afterwards ignored.
      req_cmd_v_i = 2'b01; #1;
      chk("mrst_g0", req_cmd_yumi_o, 2'b01);
      cyc(); req_cmd_v_i = 2'b11; #1;
      reset_n_i = 1'b0; clint_resp_v_i = 1'b1; req_resp_yumi_i = 2'b11; #1;
      chk("mrst_cmd_v", clint_cmd_v_o, 0);
      chk("mrst_resp_v", req_resp_v_o, 0);
      cyc(); reset_n_i = 1'b1; #1;
      chk("mrst_stray_v", req_resp_v_o, 0);
      chk("mrst_stray_yumi", clint_resp_yumi_o, 0);
      chk("mrst_rr_zero", req_cmd_yumi_o, 2'b01);
      cyc(); req_cmd_v_i = '0; cyc(); idle();

`ifdef BP_CLINT_ARB_TIMEOUT_EN
      // Withheld response: timeout after 8 stalled cycles, then sticky.
      req_cmd_v_i = 2'b01; #1;
      chk("wd_g0", req_cmd_yumi_o, 2'b01);
      cyc(); req_cmd_v_i = '0;
      repeat (7) cyc();
      chk("wd_before", timeout_o, 0);
      cyc();
      chk("wd_fire", timeout_o, 1);
      clint_resp_v_i = 1'b1; req_resp_yumi_i = 2'b11; #1;
      chk("wd_resp", clint_resp_yumi_o, 1);
      cyc(); idle(); #1;
      chk("wd_sticky", timeout_o, 1);
`else
      chk("wd_tied_low", timeout_o, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bp_clint_arb.md
BP_CLINT_ARB -- requirements
Module: bp_clint_arb

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg; it sets proc params and xce_mem_msg_width_lp.
REQ-002 SHALL have parameter num_req_p, default 2; the number of command requesters, legal range 2..4.
REQ-003 SHALL have parameter max_outstanding_p, default 2; the number of in-flight CLINT commands.
REQ-004 SHALL have parameter timeout_p, default 255; watchdog limit in cycles, used only when BP_CLINT_ARB_TIMEOUT_EN is defined.
REQ-005 SHALL have port clk_i  input  1  the single clock.
REQ-006 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_cmd_i  input  num_req_p*xce_mem_msg_width_lp  requester command messages.
REQ-008 SHALL have port req_cmd_v_i  input  num_req_p  requester command valids.
REQ-009 SHALL have port req_cmd_yumi_o  output  num_req_p  one-hot command accept.
REQ-010 SHALL have port req_resp_o  output  xce_mem_msg_width_lp  response message, broadcast to all requesters.
REQ-011 SHALL have port req_resp_v_o  output  num_req_p  one-hot response valid.
REQ-012 SHALL have port req_resp_yumi_i  input  num_req_p  requester response accept.
REQ-013 SHALL have port clint_cmd_o  output  xce_mem_msg_width_lp  command to the CLINT slice.
REQ-014 SHALL have port clint_cmd_v_o  output  1  command valid to the CLINT slice.
REQ-015 SHALL have port clint_cmd_ready_i  input  1  CLINT slice ready.
REQ-016 SHALL have port clint_resp_i  input  xce_mem_msg_width_lp  response from the CLINT slice.
REQ-017 SHALL have port clint_resp_v_i  input  1  response valid from the CLINT slice.
REQ-018 SHALL have port clint_resp_yumi_o  output  1  response accept to the CLINT slice.
REQ-019 SHALL have port timeout_o  output  1  sticky watchdog error flag.

Function
REQ-020 SHALL be issue-eligible when the tag FIFO is not full; clint_cmd_v_o = eligible & |req_cmd_v_i.
REQ-021 SHALL grant round-robin, searching from priority pointer rr_r upward with wrap past num_req_p-1 to 0; clint_cmd_o is the granted requester's message, combinationally (zero latency).
REQ-022 SHALL assert req_cmd_yumi_o[g] only when clint_cmd_v_o & clint_cmd_ready_i; on that cycle rr_r <= (g+1) mod num_req_p and g is enqueued as tag.
REQ-023 SHALL hold rr_r unchanged on cycles without an accept.
REQ-024 SHALL deassert clint_cmd_v_o when the tag FIFO is full, even if a tag dequeues on the same cycle (no full bypass).
REQ-025 SHALL drive req_resp_o = clint_resp_i, and req_resp_v_o[t] = clint_resp_v_i & tag_v for t = tag FIFO head (all other bits 0).
REQ-026 SHALL drive clint_resp_yumi_o = req_resp_yumi_i[t] & req_resp_v_o[t], and dequeue the tag on that cycle.
REQ-027 SHALL return responses strictly in issue order.
REQ-028 SHALL allow enqueue and dequeue on the same cycle when the FIFO is not full.
REQ-029 SHALL hold clint_resp_i unconsumed when clint_resp_v_i=1 with an empty tag FIFO (req_resp_v_o=0, clint_resp_yumi_o=0).
REQ-030 SHALL ignore req_resp_yumi_i bits for non-head requesters.

Reset
REQ-031 SHALL, while reset_n_i=0, clear all state asynchronously: rr_r=0, tag FIFO empty, watchdog count=0, timeout_o=0.
REQ-032 SHALL hold all outputs low during reset, and discard in-flight tags if reset occurs mid-transaction.

Configuration
REQ-033 SHALL, with BP_CLINT_ARB_TIMEOUT_EN defined, run a watchdog counter that increments each cycle the tag FIFO is non-empty with no dequeue, and clears on dequeue or when the FIFO is empty.
REQ-034 SHALL, with BP_CLINT_ARB_TIMEOUT_EN defined, set timeout_o when the watchdog count reaches timeout_p; timeout_o is sticky until reset, the counter saturates, and arbitration is unaffected.
REQ-035 SHALL, without BP_CLINT_ARB_TIMEOUT_EN, tie timeout_o to 0 and instantiate no counter.

Structure
REQ-036 SHALL implement the tag FIFO as one bsg_fifo_1r1w_small instance (width $clog2(num_req_p), depth max_outstanding_p), with asynchronous reset handled inside bp_clint_arb.
REQ-037 SHALL place clint_arb_max_req_gp (4) and the default timeout constant in bp_common_pkg; no new typedefs, and messages use bp_xce_mem_msg_s.

Verification
REQ-038 SHALL cover: req 0 and req 1 valid continuously, CLINT always ready -> grants alternate 0,1,0,1 with rr_r starting at 0.
REQ-039 SHALL cover: 2 commands accepted, CLINT response delayed -> third command blocked (clint_cmd_v_o=0) until the first response is yumi'd.
REQ-040 SHALL cover: issue req1 then req0, with responses A then B -> A is routed to req_resp_v_o=2'b10 and B to 2'b01.
REQ-041 SHALL cover: head requester holds yumi low for 5 cycles -> clint_resp_yumi_o=0 for those 5 cycles and the response stays pending.
REQ-042 SHALL cover: reset_n_i dropped with 1 tag outstanding -> FIFO empty and a subsequent stray clint_resp_v_i is not consumed.
REQ-043 SHALL cover, with the macro defined and timeout_p=8: response withheld -> timeout_o=1 after 8 cycles and stays 1 after the response arrives.
